// File: rtl/if_fetch_stage_pkg.sv
// Core-wide fetch definitions: data widths, reset pc, fetch entry payload.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch: the pc it was fetched from and the returned word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_stage_sync_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush.
module if_fetch_stage_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Handshake qualification; a pop in the same cycle makes room for a push.
  always_comb begin
    empty     = (count == '0);
    full      = (count == CW'(DEPTH));
    do_pop    = pop & ~empty & ~flush;
    do_push   = push & ~flush & (~full | do_pop);
    head_data = mem[rd_ptr];
  end

  // Pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, written on accepted push only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Callers guarantee space; a dropped push would silently lose a fetch.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (push && !flush) |-> (!full || pop));

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    (pop && !flush) |-> !empty);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: issues in-order word fetches, buffers {pc, instr} for decode,
// steers the pc register and squashes stale fetches on EX redirects.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  input  logic            id_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   pend_count;
  logic [OW-1:0]   occupancy;
  logic [XLEN-1:0] pend_head;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            fifo_empty;
  logic            credit;
  logic            id_pop;
  logic            issue;
  logic            resp_pop;
  logic            resp_keep;

  // Credit, handshakes and response steering. A same-cycle decode pop frees
  // a slot so the stage sustains one fetch per cycle at unit memory latency.
  always_comb begin
    fifo_empty     = (fifo_count == '0);
    id_valid       = reset & ~fifo_empty & ~redirect_valid;
    id_pop         = id_valid & id_ready;
    occupancy      = OW'(inflight) + OW'(fifo_count) - OW'(id_pop);
    credit         = (occupancy < OW'(DEPTH));
    imem_req_valid = reset & ~redirect_valid & credit;
    imem_req_addr  = pc;
    issue          = imem_req_valid & imem_req_ready;
    resp_pop       = reset & imem_resp_valid;
    resp_keep      = resp_pop & ~redirect_valid & (drop_cnt == '0);
    push_entry     = '{pc: pend_head, instr: imem_resp_data};
    id_pc          = head_entry.pc;
    id_instr       = fifo_empty ? INSTR_NOP : head_entry.instr;
  end

  // Next pc for the pc register: reset, then redirect, then sequential advance.
  always_comb begin
    pc_next = pc;
    if (!reset) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = align_word(redirect_target);
    end else if (issue) begin
      pc_next = pc + XLEN'(4);
    end
  end

  // Outstanding fetch count and number of stale responses still to discard.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(resp_pop);
      if (redirect_valid) begin
        drop_cnt <= inflight - CW'(resp_pop);
      end else if (resp_pop && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Decoded-side buffer of {pc, instr}.
  if_fetch_stage_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (id_pop),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  // Pcs of fetches awaiting a response, popped in step with every response.
  if_fetch_stage_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pend_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (issue),
    .push_data (pc),
    .pop       (resp_pop),
    .head_data (pend_head),
    .count     (pend_count)
  );

  a_pend_tracks_inflight: assert property (@(posedge clk) disable iff (!reset)
    pend_count == inflight);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a pc register and latency-programmable memory.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready = 1'b1;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned mem_lat = 1;
  int unsigned cyc = 0;
  logic [31:0] got_pc[$];

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;
  mreq_t mq[$];

  if_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_next         (pc_next),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_instr        (id_instr),
    .id_ready        (id_ready)
  );

  always #5 clk = ~clk;

  // pc register loads pc_next every cycle
  always @(posedge clk) pc <= pc_next;

  // In-order memory: request at cycle T answers in cycle T+mem_lat with ~addr
  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready)
        mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      if (mq.size() > 0 && mq[0].due == cyc + 1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= ~mq[0].addr;
        void'(mq.pop_front());
      end else begin
        imem_resp_valid <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle and log any decode handshake this cycle
  task automatic settle();
    #1;
    if (id_valid === 1'b1 && id_ready) got_pc.push_back(id_pc);
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset();
    reset           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_req_ready  = 1'b1;
    id_ready        = 1'b1;
    nxt();
    #1;
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    nxt();
    reset = 1'b1;
    got_pc.delete();
  endtask

  initial begin
    // 1: reset then stream at L=1
    mem_lat = 1;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      settle();
      chk("t1_id_valid", 32'(id_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        chk("t1_id_pc", id_pc, 32'(4 * (k - 2)));
        chk("t1_id_instr", id_instr, ~32'(4 * (k - 2)));
      end
      if (k == 0) chk("t1_pc_next", pc_next, 32'd4);
      nxt();
    end

    // 2: memory stall at pc=8 for 3 cycles
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k == 2) imem_req_ready = 1'b0;
      if (k == 5) imem_req_ready = 1'b1;
      settle();
      if (k >= 2 && k <= 4) chk("t2_pc_hold", pc_next, 32'd8);
      nxt();
    end
    chk("t2_count", 32'(got_pc.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t2_seq", got_at(i), 32'(4 * i));

    // 3: decode backpressure for 5 cycles with a full FIFO
    do_reset();
    for (int k = 0; k < 11; k++) begin
      id_ready = (k >= 7);
      settle();
      if (k >= 2 && k <= 6) begin
        chk("t3_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t3_id_valid", 32'(id_valid), 32'd1);
        chk("t3_id_pc", id_pc, 32'h0);
        chk("t3_id_instr", id_instr, 32'hFFFF_FFFF);
      end
      if (k == 7) begin
        chk("t3_req_resume", 32'(imem_req_valid), 32'd1);
        chk("t3_pc_next", pc_next, 32'd12);
      end
      nxt();
    end
    chk("t3_count", 32'(got_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_seq", got_at(i), 32'(4 * i));

    // 4: redirect with two fetches in flight at L=3
    mem_lat = 3;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      redirect_valid  = (k == 0) || (k == 3);
      redirect_target = (k == 0) ? 32'd16 : 32'h100;
      settle();
      if (k == 0) begin
        chk("t4_redir_wins", 32'(imem_req_valid), 32'd0);
        chk("t4_pc_next0", pc_next, 32'd16);
      end
      if (k == 1) chk("t4_addr16", imem_req_addr, 32'd16);
      if (k == 2) chk("t4_addr20", imem_req_addr, 32'd20);
      if (k == 3) begin
        chk("t4_redir_noreq", 32'(imem_req_valid), 32'd0);
        chk("t4_pc_next3", pc_next, 32'h100);
      end
      if (k == 5) begin
        chk("t4_req_valid5", 32'(imem_req_valid), 32'd1);
        chk("t4_addr100", imem_req_addr, 32'h100);
      end
      nxt();
    end
    redirect_valid = 1'b0;
    chk("t4_count", 32'(got_pc.size()), 32'd2);
    chk("t4_first", got_at(0), 32'h100);
    chk("t4_second", got_at(1), 32'h104);

    // 5: redirect coinciding with a response and a decode handshake
    mem_lat = 1;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      redirect_valid  = (k == 2);
      redirect_target = 32'h40;
      settle();
      if (k == 2) begin
        chk("t5_id_valid", 32'(id_valid), 32'd0);
        chk("t5_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t5_pc_next", pc_next, 32'h40);
      end
      if (k == 3 || k == 4) chk("t5_no_stale", 32'(id_valid), 32'd0);
      nxt();
    end
    redirect_valid = 1'b0;
    chk("t5_count", 32'(got_pc.size()), 32'd2);
    chk("t5_first", got_at(0), 32'h40);
    chk("t5_second", got_at(1), 32'h44);

    // 6: pc wrap and redirect alignment
    do_reset();
    for (int k = 0; k < 8; k++) begin
      redirect_valid  = (k == 0) || (k == 4);
      redirect_target = (k == 0) ? 32'hFFFF_FFFC : 32'h203;
      settle();
      if (k == 0) chk("t6_pc_next_top", pc_next, 32'hFFFF_FFFC);
      if (k == 1) begin
        chk("t6_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        chk("t6_wrap", pc_next, 32'h0);
      end
      if (k == 3) begin
        chk("t6_id_valid", 32'(id_valid), 32'd1);
        chk("t6_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("t6_id_instr", id_instr, 32'h0000_0003);
      end
      if (k == 4) begin
        chk("t6_align", pc_next, 32'h200);
        chk("t6_redir_noreq", 32'(imem_req_valid), 32'd0);
      end
      if (k == 5 || k == 6) chk("t6_flushed", 32'(id_valid), 32'd0);
      if (k == 7) begin
        chk("t6_target_valid", 32'(id_valid), 32'd1);
        chk("t6_target_pc", id_pc, 32'h200);
      end
      nxt();
    end
    redirect_valid = 1'b0;

    // Mid-operation reset with a fetch outstanding
    do_reset();
    settle();
    chk("t7_req_after_rst", 32'(imem_req_valid), 32'd1);
    chk("t7_addr_after_rst", imem_req_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly downstream of the pc register. It consumes the current pc and issues in-order word fetches to instruction memory over a valid/ready request port. It buffers {pc, instr} pairs in a small FIFO for decode, and drives pc_next back into the pc register. Branch/jump redirects from EX flush buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, value driven on pc_next while reset is asserted.
DEPTH, 2, output FIFO entries; also the maximum in-flight plus buffered fetches (power of two, ≥2).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  reset; synchronous, active-low (0 = reset).
pc  in  32  current pc from the pc register.
pc_next  out  32  next pc into the pc register (combinational; the register loads it every cycle).
imem_req_valid  out  1  fetch request valid.
imem_req_addr  out  32  fetch byte address, equal to pc.
imem_req_ready  in  1  memory accepts the request.
imem_resp_valid  in  1  in-order response valid; latency ≥1 cycle, no backpressure.
imem_resp_data  in  32  instruction word.
redirect_valid  in  1  EX redirect (taken branch/jump).
redirect_target  in  32  redirect pc; bits [1:0] are ignored and treated as 00.
id_valid  out  1  decode entry valid.
id_pc  out  32  pc of the head entry.
id_instr  out  32  instruction of the head entry.
id_ready  in  1  decode accepts the entry.

Behaviour:
- Reset (reset==0 at a clk edge): clear FIFO, pending-pc queue, inflight count and drop count. While reset==0: pc_next=RESET_PC, imem_req_valid=0, id_valid=0.
- Credit: inflight + fifo_count < DEPTH.
- imem_req_valid = reset & ~redirect_valid & credit.
- imem_req_addr = pc.
- Issue = imem_req_valid & imem_req_ready. On issue, push pc into the pending-pc queue (depth DEPTH) and increment inflight.
- pc_next priority:
  - reset asserted -> RESET_PC
  - redirect_valid -> {redirect_target[31:2], 2'b00}
  - issue -> pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
  - otherwise -> pc (hold)
- Response handling (each imem_resp_valid decrements inflight and pops the pending-pc queue):
  - drop_cnt>0: discard, drop_cnt--.
  - Otherwise: push {popped pc, imem_resp_data} into the FIFO.
- Redirect cycle:
  - FIFO flushed.
  - No issue.
  - Any response in that cycle is discarded.
  - drop_cnt <= inflight - imem_resp_valid (all older fetches become stale).
  - Pending-pc queue keeps popping in step with responses.
- Decode handshake:
  - id_valid = reset & (fifo_count>0) & ~redirect_valid.
  - id_pc/id_instr come from the FIFO head, are registered, and stay stable while id_valid & ~id_ready.
  - Pop on id_valid & id_ready.
- Push and pop in the same cycle are legal. Overflow is impossible by construction of credit; an assertion checks it.
- Latency: issue at cycle T, response at T+L, id_valid at T+L+1.
- Throughput: 1 instr/cycle with L=1 and DEPTH=2 when id_ready is held high.
- Redirect in the same cycle as an issue opportunity: the redirect wins and no request is made.
- Mid-operation reset: all state is cleared and outstanding responses are not tracked. The memory model must also reset.

Decomposition:
- Shared package (core-wide): XLEN=32, INSTR_NOP=32'h0000_0013, RESET_PC default.
- One natural sub-module: sync_fifo (parameterised width/depth, count output, flush input). Instantiate it twice: {pc,instr} FIFO of width 64 and pending-pc queue of width 32.
- Credit, drop counter and pc_next mux stay in the top level.

Test Plan:
1. Reset then stream: reset=0 for 2 cycles; RESET_PC=0; memory L=1, always ready; id_ready=1 -> id_pc sequence 0,4,8,12,16, one per cycle from the 3rd cycle after reset release; pc_next=RESET_PC during reset.
2. Memory stall: imem_req_ready=0 for 3 cycles at pc=8 -> pc_next=8 held for 3 cycles, no duplicate/missing entries, 8 delivered once after ready returns.
3. Decode backpressure: id_ready=0 for 5 cycles -> FIFO fills to 2, imem_req_valid drops, id_pc/id_instr stable, no request issued until a pop frees credit; order preserved.
4. Redirect with in-flight fetches: L=3, two requests outstanding (pc 16,20), redirect_target=32'h100 -> both stale responses dropped, FIFO flushed, next id_pc=32'h100, 32'h104.
5. Redirect coinciding with a response and an id handshake: same cycle -> response discarded, no pop counted, id_valid=0 that cycle, next entry is the target.
6. Wrap/alignment: pc=32'hFFFF_FFFC issued -> pc_next=0; redirect_target=32'h203 -> pc_next=32'h200.
